// File: rtl/freqmeter_pkg.sv
// Shared definitions for the freqmeter: channel FSM encoding and default sizes.
package freqmeter_pkg;

    // Channel measurement sequence
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } chan_state_e;

    localparam int PERIOD_W_DEF     = 24;
    localparam int CNT_W_DEF        = 32;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int TIMEOUT_DEF      = 2**24;
    localparam int NUM_CHANNELS     = 8;

endpackage : freqmeter_pkg

// File: rtl/fin_edge_detect.sv
// Synchronizes the asynchronous Fin pin and produces a one-cycle rising-edge pulse.
// The lag from pin to pulse is fixed, so the spacing between pulses is exact.
module fin_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fin_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain followed by one history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : fin_edge_detect

// File: rtl/freqmeter_channel.sv
// Reciprocal frequency-measurement channel: counts an integer number of Fin periods
// and the clk_i cycles they span, reporting the pair through a start/done handshake.
module freqmeter_channel
    import freqmeter_pkg::*;
#(
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fin_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [PERIOD_W-1:0] periods_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [PERIOD_W-1:0] period_cnt_o,
    output logic [CNT_W-1:0]    clk_cnt_o,
    output logic                timeout_o,
    output logic                ovf_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    chan_state_e         state_q;
    logic [PERIOD_W-1:0] target_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [CNT_W-1:0]    clk_cnt_q;
    logic [TO_W-1:0]     idle_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic                ovf_q;

    logic                rise_s;
    logic                clk_at_max_s;
    logic                idle_expire_s;
    logic [CNT_W-1:0]    clk_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_d;
    logic [TO_W-1:0]     idle_cnt_d;
    logic [PERIOD_W-1:0] target_d;

    fin_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .fin_i  (fin_i),
        .rise_o (rise_s)
    );

    // Counter increments: saturating clock count, period count, idle-edge watchdog
    always_comb begin
        clk_at_max_s  = &clk_cnt_q;
        clk_cnt_d     = clk_at_max_s ? clk_cnt_q : clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        period_cnt_d  = period_cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
        idle_cnt_d    = idle_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        idle_expire_s = (idle_cnt_d == TO_W'(TIMEOUT));
        if (periods_i == {PERIOD_W{1'b0}}) begin
            target_d = {{(PERIOD_W-1){1'b0}}, 1'b1};
        end else begin
            target_d = periods_i;
        end
    end

    // Measurement FSM with counters and registered result/status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            period_cnt_q <= '0;
            clk_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        target_q     <= target_d;
                        period_cnt_q <= '0;
                        clk_cnt_q    <= '0;
                        idle_cnt_q   <= '0;
                        timeout_q    <= 1'b0;
                        ovf_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ARMED;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (rise_s) begin
                        clk_cnt_q    <= '0;
                        period_cnt_q <= '0;
                        idle_cnt_q   <= '0;
                        state_q      <= ST_MEASURE;
                    end else if (idle_expire_s) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                ST_MEASURE: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_d;
                        if (clk_at_max_s) begin
                            ovf_q <= 1'b1;
                        end else begin
                            ovf_q <= ovf_q;
                        end
                        if (rise_s) begin
                            // A rise on the expiry cycle wins over the timeout
                            period_cnt_q <= period_cnt_d;
                            idle_cnt_q   <= '0;
                            if (period_cnt_d == target_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_MEASURE;
                            end
                        end else if (idle_expire_s) begin
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_DONE;
                        end else begin
                            idle_cnt_q <= idle_cnt_d;
                        end
                    end
                end
                ST_DONE: begin
                    // start_i here is ignored: only IDLE accepts a new request
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign period_cnt_o = period_cnt_q;
    assign clk_cnt_o    = clk_cnt_q;
    assign timeout_o    = timeout_q;
    assign ovf_o        = ovf_q;

endmodule : freqmeter_channel

// File: tb/tb_freqmeter_channel.sv
// Directed self-checking bench for freqmeter_channel. Three instances share Fin:
// A (TIMEOUT=1000), B (default timeout, long periods), C (CNT_W=8, overflow).
module tb_freqmeter_channel;

    logic        clk;
    logic        rst_n;
    logic        fin;
    logic        abort;
    logic [23:0] periods;
    logic        start_a, start_b, start_c;

    logic        busy_a, done_a, to_a, ovf_a;
    logic [23:0] pc_a;
    logic [31:0] cc_a;
    logic        busy_b, done_b, to_b, ovf_b;
    logic [23:0] pc_b;
    logic [31:0] cc_b;
    logic        busy_c, done_c, to_c, ovf_c;
    logic [23:0] pc_c;
    logic [7:0]  cc_c;

    int checks = 0;
    int errors = 0;

    // Fin pattern generator state
    int fin_per = 0;
    int fin_hi  = 0;
    int fin_ph  = 0;

    freqmeter_channel #(.PERIOD_W(24), .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .fin_i(fin), .start_i(start_a), .abort_i(abort),
        .periods_i(periods), .busy_o(busy_a), .done_o(done_a), .period_cnt_o(pc_a),
        .clk_cnt_o(cc_a), .timeout_o(to_a), .ovf_o(ovf_a));

    freqmeter_channel #(.PERIOD_W(24), .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(2**24)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .fin_i(fin), .start_i(start_b), .abort_i(abort),
        .periods_i(periods), .busy_o(busy_b), .done_o(done_b), .period_cnt_o(pc_b),
        .clk_cnt_o(cc_b), .timeout_o(to_b), .ovf_o(ovf_b));

    freqmeter_channel #(.PERIOD_W(24), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .fin_i(fin), .start_i(start_c), .abort_i(abort),
        .periods_i(periods), .busy_o(busy_c), .done_o(done_c), .period_cnt_o(pc_c),
        .clk_cnt_o(cc_c), .timeout_o(to_c), .ovf_o(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fin waveform: high for fin_hi of every fin_per cycles, held low when fin_per is 0
    initial begin
        fin = 1'b0;
        forever begin
            @(negedge clk);
            if (fin_per == 0) begin
                fin = 1'b0;
            end else begin
                fin = (fin_ph < fin_hi);
                fin_ph = (fin_ph + 1) % fin_per;
            end
        end
    end

    task automatic set_fin(input int per, input int hi);
        fin_ph  = 0;
        fin_hi  = hi;
        fin_per = per;
    endtask

    task automatic pulse_start(input int sel, input logic [23:0] p);
        @(negedge clk);
        periods = p;
        if (sel == 0) start_a = 1'b1;
        else if (sel == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    function automatic logic done_of(input int sel);
        if (sel == 0) return done_a;
        else if (sel == 1) return done_b;
        else return done_c;
    endfunction

    // Waits (bounded) until the selected instance shows done at a negedge sample
    task automatic wait_done(input int sel, input int budget, output int cycles);
        cycles = 0;
        while (done_of(sel) !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (done_of(sel) !== 1'b1) begin
            errors++;
            $display("FAIL done_wait sel=%0d: done not seen within %0d cycles", sel, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, to_a, ovf_a, pc_a, cc_a} !== 60'd0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b done=%b pc=%0d cc=%0d to=%b ovf=%b, want all 0",
                     busy_a, done_a, pc_a, cc_a, to_a, ovf_a);
        end
        checks++;
        if ({busy_c, done_c, to_c, ovf_c, pc_c, cc_c} !== 36'd0) begin
            errors++;
            $display("FAIL reset_c: got busy=%b pc=%0d cc=%0d, want 0", busy_c, pc_c, cc_c);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        set_fin(16, 8);
        pulse_start(0, 24'd10);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy_a);
        end
        repeat (30) @(negedge clk);
        pulse_start(0, 24'd2);            // ignored while busy
        wait_done(0, 400, cyc);
        checks++;
        if (pc_a !== 24'd10 || cc_a !== 32'd160) begin
            errors++;
            $display("FAIL basic_result: got pc=%0d cc=%0d want pc=10 cc=160", pc_a, cc_a);
        end
        checks++;
        if (busy_a !== 1'b0 || to_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got busy=%b to=%b ovf=%b want 0/0/0", busy_a, to_a, ovf_a);
        end
        // start presented in the DONE cycle must be ignored
        start_a = 1'b1;
        periods = 24'd3;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_start: got done=%b busy=%b want 0/0", done_a, busy_a);
        end
        checks++;
        if (pc_a !== 24'd10 || cc_a !== 32'd160) begin
            errors++;
            $display("FAIL basic_hold: got pc=%0d cc=%0d want 10/160", pc_a, cc_a);
        end
    endtask

    task automatic test_gated();
        int cyc;
        set_fin(1024, 4);
        pulse_start(1, 24'd3);
        wait_done(1, 6000, cyc);
        checks++;
        if (pc_b !== 24'd3 || cc_b !== 32'd3072 || to_b !== 1'b0) begin
            errors++;
            $display("FAIL gated_result: got pc=%0d cc=%0d to=%b want 3/3072/0", pc_b, cc_b, to_b);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        set_fin(0, 0);
        repeat (5) @(negedge clk);
        pulse_start(0, 24'd5);
        wait_done(0, 1500, cyc);
        checks++;
        if (cyc < 990 || cyc > 1010) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles want about 1000", cyc);
        end
        checks++;
        if (to_a !== 1'b1 || pc_a !== 24'd0 || cc_a !== 32'd0) begin
            errors++;
            $display("FAIL timeout_result: got to=%b pc=%0d cc=%0d want 1/0/0", to_a, pc_a, cc_a);
        end
    endtask

    task automatic test_zero_periods();
        int cyc;
        set_fin(4, 2);
        pulse_start(0, 24'd0);
        wait_done(0, 100, cyc);
        checks++;
        if (pc_a !== 24'd1 || cc_a !== 32'd4 || to_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_periods: got pc=%0d cc=%0d to=%b want 1/4/0", pc_a, cc_a, to_a);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int seen;
        set_fin(16, 8);
        pulse_start(0, 24'd100);
        repeat (40) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b want 0", busy_a);
        end
        // start and abort together in IDLE: abort wins
        start_a = 1'b1;
        abort   = 1'b1;
        periods = 24'd2;
        @(negedge clk);
        start_a = 1'b0;
        abort   = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_busy: got %b want 0", busy_a);
        end
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        pulse_start(0, 24'd2);
        wait_done(0, 200, cyc);
        checks++;
        if (pc_a !== 24'd2 || cc_a !== 32'd32) begin
            errors++;
            $display("FAIL after_abort: got pc=%0d cc=%0d want 2/32", pc_a, cc_a);
        end
    endtask

    task automatic test_ovf();
        int cyc;
        set_fin(64, 32);
        pulse_start(2, 24'd8);
        wait_done(2, 1000, cyc);
        checks++;
        if (ovf_c !== 1'b1 || cc_c !== 8'd255 || pc_c !== 24'd8 || to_c !== 1'b0) begin
            errors++;
            $display("FAIL ovf_result: got ovf=%b cc=%0d pc=%0d to=%b want 1/255/8/0",
                     ovf_c, cc_c, pc_c, to_c);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        set_fin(16, 8);
        pulse_start(0, 24'd50);
        repeat (60) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || pc_a == 24'd0) begin
            errors++;
            $display("FAIL reset_mid_pre: got busy=%b pc=%0d want busy=1 pc>0", busy_a, pc_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, to_a, ovf_a, pc_a, cc_a} !== 60'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy=%b pc=%0d cc=%0d want 0", busy_a, pc_a, cc_a);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        abort   = 1'b0;
        periods = 24'd0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        test_reset();
        test_basic();
        test_gated();
        test_timeout();
        test_zero_periods();
        test_abort();
        test_ovf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_freqmeter_channel
